// File: rtl/peripheral_hub_pkg.sv
// Shared register map, snapshot FSM encoding and constants for peripheral_hub.
package peripheral_hub_pkg;

  localparam logic [31:0] MAILBOX       = 32'h0000_0000;
  localparam logic [31:0] COMM_CONTROL  = 32'h0000_0004;
  localparam logic [31:0] PHASE         = 32'h0000_0008;
  localparam logic [31:0] METRIC        = 32'h0000_000C;
  localparam logic [31:0] RESET_CONTROL = 32'h0000_0010;
  localparam logic [31:0] STATS_SNAP    = 32'h0000_0014;
  localparam logic [31:0] STATS_IDX     = 32'h0000_0018;
  localparam logic [31:0] STATS_DATA    = 32'h0000_001C;
  localparam logic [31:0] STATS_STATUS  = 32'h0000_0020;
  localparam logic [31:0] CACHE_BASE    = 32'h0000_0040;

  localparam logic [31:0] DEADBEAF      = 32'hDEAD_BEAF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } snap_state_e;

endpackage

// File: rtl/peripheral_hub_stats_snapshot.sv
// Cycle-counter snapshot: capture FSM, snapshot array and auto-incrementing read index.
module stats_snapshot
  import peripheral_hub_pkg::*;
#(
  parameter int unsigned N_CNT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 snap_i,
  input  logic                 idx_wr_i,
  input  logic [31:0]          idx_data_i,
  input  logic                 data_rd_i,
  input  logic                 status_rd_i,
  input  logic [32*N_CNT-1:0]  cnt_i,
  output logic [31:0]          data_o,
  output logic [31:0]          status_o
);

  localparam int unsigned IDX_W = (N_CNT > 1) ? $clog2(N_CNT) : 1;

  snap_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [31:0]      snap_q [N_CNT];
  logic [31:0]      snap_d [N_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < N_CNT; k++) snap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      for (int unsigned k = 0; k < N_CNT; k++) snap_q[k] <= snap_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    snap_d  = snap_q;
    if (status_rd_i) err_d = 1'b0;
    case (state_q)
      IDLE: if (snap_i) state_d = CAPTURE;
      CAPTURE: begin
        for (int unsigned k = 0; k < N_CNT; k++) snap_d[k] = cnt_i[32*k +: 32];
        idx_d   = '0;
        state_d = READY;
      end
      READY: begin
        // A snap request alongside a data read still serves the old word; capture resets idx.
        if (data_rd_i) idx_d = (idx_q == IDX_W'(N_CNT - 1)) ? '0 : idx_q + 1'b1;
        if (idx_wr_i) begin
          if (idx_data_i < N_CNT) idx_d = idx_data_i[IDX_W-1:0];
          else                    err_d = 1'b1;
        end
        if (snap_i) state_d = CAPTURE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d = IDLE;
      idx_d   = '0;
      err_d   = 1'b0;
      for (int unsigned k = 0; k < N_CNT; k++) snap_d[k] = '0;
    end
  end

  assign data_o   = (state_q == READY) ? snap_q[idx_q] : '0;
  assign status_o = {29'b0, err_q, state_q};

endmodule

// File: rtl/peripheral_hub.sv
// Core/CS register hub: mailbox, comm/phase/metric controls, cache status and counter snapshots.
module peripheral_hub
  import peripheral_hub_pkg::*;
#(
  parameter int unsigned N_CACHE = 3,
  parameter int unsigned N_CNT   = 6,
  parameter int unsigned ADDR_W  = 26
) (
  input  logic                  clock_i,
  input  logic                  cpu_resetn_i,
  input  logic                  req_core_i,
  input  logic                  rw_core_i,
  input  logic [ADDR_W-1:0]     add_core_i,
  input  logic [31:0]           data_core_i,
  output logic [31:0]           data_core_o,
  input  logic                  req_cs_i,
  input  logic                  rw_cs_i,
  input  logic [ADDR_W-1:0]     add_cs_i,
  input  logic [31:0]           data_cs_i,
  output logic [31:0]           data_cs_o,
  input  logic [32*N_CNT-1:0]   cycle_counts_i,
  input  logic [32*N_CACHE-1:0] comm_cache_i,
  output logic [1:0]            metric_sel_o,
  output logic [18:0]           shift_sample_rate_o,
  output logic [31:0]           phase_o,
  output logic [31:0]           comm_o,
  output logic                  reset_system_o
);

  logic [1:0]  reset_reg_q, reset_reg_d;
  logic [31:0] mailbox_q, mailbox_d;
  logic [31:0] comm_q, comm_d;
  logic [31:0] phase_q, phase_d;
  logic [1:0]  metric_q, metric_d;
  logic [18:0] shift_q, shift_d;
  logic [31:0] data_core_q, data_core_d;
  logic [31:0] data_cs_q, data_cs_d;

  logic        en;
  logic        core_wr, core_rd, cs_wr, cs_rd;
  logic        core_mbx, core_comm, core_phase;
  logic        cs_mbx, cs_comm, cs_phase, cs_metric, cs_rst;
  logic        cs_snap, cs_idx, cs_sdata, cs_status;
  logic [31:0] core_rdata, cs_rdata, rst_word;
  logic [31:0] stat_data, stat_status;
  logic [15:0] shift_field;
  logic [4:0]  shift_enc;

  assign en       = reset_reg_q[1];
  assign core_wr  = req_core_i &  rw_core_i;
  assign core_rd  = req_core_i & ~rw_core_i;
  assign cs_wr    = req_cs_i   &  rw_cs_i;
  assign cs_rd    = req_cs_i   & ~rw_cs_i;
  assign rst_word = {30'h3FFF_FFFF, reset_reg_q};

  assign core_mbx   = (add_core_i == ADDR_W'(MAILBOX));
  assign core_comm  = (add_core_i == ADDR_W'(COMM_CONTROL));
  assign core_phase = (add_core_i == ADDR_W'(PHASE));
  assign cs_mbx     = (add_cs_i == ADDR_W'(MAILBOX));
  assign cs_comm    = (add_cs_i == ADDR_W'(COMM_CONTROL));
  assign cs_phase   = (add_cs_i == ADDR_W'(PHASE));
  assign cs_metric  = (add_cs_i == ADDR_W'(METRIC));
  assign cs_rst     = (add_cs_i == ADDR_W'(RESET_CONTROL));
  assign cs_snap    = (add_cs_i == ADDR_W'(STATS_SNAP));
  assign cs_idx     = (add_cs_i == ADDR_W'(STATS_IDX));
  assign cs_sdata   = (add_cs_i == ADDR_W'(STATS_DATA));
  assign cs_status  = (add_cs_i == ADDR_W'(STATS_STATUS));

  // Leading-one encoder: 15 - msb_index(field), 16 for an empty field.
  assign shift_field = data_cs_i[17:2];
  always_comb begin
    shift_enc = 5'd16;
    for (int unsigned b = 0; b < 16; b++) begin
      if (shift_field[b]) shift_enc = 5'(15 - b);
    end
  end

  always_comb begin
    reset_reg_d = reset_reg_q;
    if (cs_wr && cs_rst) reset_reg_d = data_cs_i[1:0];

    mailbox_d = mailbox_q;
    if (core_wr && core_mbx) mailbox_d = data_core_i;
    if (cs_wr && cs_mbx)     mailbox_d = data_cs_i;

    comm_d = comm_q & ~32'h00C0_0000;
    if (core_wr && core_comm) comm_d[31:24] = data_core_i[7:0];
    if (cs_wr && cs_comm)     comm_d[23:0]  = data_cs_i[23:0];

    phase_d = {1'b0, phase_q[30:0]};
    if (core_wr && core_phase) phase_d = {1'b1, data_core_i[30:0]};

    metric_d = metric_q;
    shift_d  = shift_q;
    if (cs_wr && cs_metric) begin
      metric_d = data_cs_i[1:0];
      shift_d  = (data_cs_i[1:0] == 2'd1) ? {data_cs_i[31:18], shift_enc} : data_cs_i[20:2];
    end

    if (!en) begin
      mailbox_d = '0;
      comm_d    = '0;
      phase_d   = '0;
      metric_d  = '0;
      shift_d   = '0;
    end
  end

  always_comb begin
    core_rdata = '0;
    if (core_mbx)   core_rdata = mailbox_q;
    if (core_comm)  core_rdata = comm_q;
    if (core_phase) core_rdata = phase_q;

    cs_rdata = '0;
    if (cs_mbx)    cs_rdata = mailbox_q;
    if (cs_comm)   cs_rdata = comm_q;
    if (cs_phase)  cs_rdata = phase_q;
    if (cs_metric) cs_rdata = {11'b0, shift_q, metric_q};
    if (cs_rst)    cs_rdata = rst_word;
    if (cs_sdata)  cs_rdata = stat_data;
    if (cs_status) cs_rdata = stat_status;
    for (int unsigned i = 0; i < N_CACHE; i++) begin
      if (add_cs_i == ADDR_W'(CACHE_BASE + 4*i)) cs_rdata = comm_cache_i[32*i +: 32];
    end

    data_core_d = data_core_q;
    if (!en)          data_core_d = DEADBEAF;
    else if (core_rd) data_core_d = core_rdata;

    data_cs_d = data_cs_q;
    if (!en)        data_cs_d = (cs_rd && cs_rst) ? rst_word : DEADBEAF;
    else if (cs_rd) data_cs_d = cs_rdata;
  end

  always_ff @(posedge clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      reset_reg_q <= '0;
      mailbox_q   <= '0;
      comm_q      <= '0;
      phase_q     <= '0;
      metric_q    <= '0;
      shift_q     <= '0;
      data_core_q <= DEADBEAF;
      data_cs_q   <= DEADBEAF;
    end else begin
      reset_reg_q <= reset_reg_d;
      mailbox_q   <= mailbox_d;
      comm_q      <= comm_d;
      phase_q     <= phase_d;
      metric_q    <= metric_d;
      shift_q     <= shift_d;
      data_core_q <= data_core_d;
      data_cs_q   <= data_cs_d;
    end
  end

  stats_snapshot #(
    .N_CNT (N_CNT)
  ) u_stats (
    .clk         (clock_i),
    .rst_n       (cpu_resetn_i),
    .clr_i       (~en),
    .snap_i      (cs_wr & cs_snap),
    .idx_wr_i    (cs_wr & cs_idx),
    .idx_data_i  (data_cs_i),
    .data_rd_i   (cs_rd & cs_sdata),
    .status_rd_i (cs_rd & cs_status),
    .cnt_i       (cycle_counts_i),
    .data_o      (stat_data),
    .status_o    (stat_status)
  );

  assign data_core_o         = data_core_q;
  assign data_cs_o           = data_cs_q;
  assign metric_sel_o        = metric_q;
  assign shift_sample_rate_o = shift_q;
  assign phase_o             = phase_q;
  assign comm_o              = comm_q;
  assign reset_system_o      = reset_reg_q[0];

endmodule

// File: doc/peripheral_hub.md
PERIPHERAL_HUB -- requirements
Module: peripheral_hub

Interface
REQ-001 Parameter N_CACHE, default 3: number of 32-bit cache comm inputs readable by the control system (CS).
REQ-002 Parameter N_CNT, default 6: number of 32-bit cycle counters presented on cycle_counts_i.
REQ-003 Parameter ADDR_W, default 26: width of both byte-address ports.
REQ-004 clock_i  in  1  single system clock; all state changes on its rising edge.
REQ-005 cpu_resetn_i  in  1  reset, asynchronous and active-low.
REQ-006 req_core_i, rw_core_i  in  1 each  core request; rw=1 write.
REQ-007 add_core_i  in  ADDR_W  core byte address; data_core_i  in  32  core write data.
REQ-008 data_core_o  out  32  core read data, registered.
REQ-009 req_cs_i, rw_cs_i  in  1 each; add_cs_i  in  ADDR_W; data_cs_i  in  32  CS port.
REQ-010 data_cs_o  out  32  CS read data, registered.
REQ-011 cycle_counts_i  in  32*N_CNT  live counters, counter k at bits [32k+31:32k].
REQ-012 comm_cache_i  in  32*N_CACHE  cache status words.
REQ-013 metric_sel_o 2, shift_sample_rate_o 19, phase_o 32, comm_o 32, reset_system_o 1  out  registered control outputs.

Function
REQ-014 Read latency SHALL be exactly one cycle on both ports; a read of an unmapped address returns 32'h0; data_*_o holds its value when no read is issued.
REQ-015 Peripheral enable = reset_reg[1]; while 0, all registers except reset_reg SHALL be held at reset values, data_core_o SHALL be 32'hDEADBEAF, and data_cs_o SHALL return {30'h3FFFFFFF, reset_reg} for RESET_CONTROL and 32'hDEADBEAF otherwise.
REQ-016 CS write to RESET_CONTROL loads reset_reg <= data[1:0] regardless of enable; reset_system_o = reset_reg[0].
REQ-017 MAILBOX: writable and readable by both ports; same-cycle writes from both ports SHALL resolve to the CS value.
REQ-018 COMM_CONTROL: core write loads comm_o[31:24] <= data[7:0]; CS write loads comm_o[23:0] <= data[23:0]; bits 23 and 22 SHALL self-clear one cycle after being set (single-cycle pulses).
REQ-019 PHASE: core write loads phase_o <= {1, data[30:0]}; bit 31 SHALL self-clear the following cycle; a new write in that cycle re-asserts it.
REQ-020 METRIC: CS write sets metric_sel_o <= data[1:0]; if data[1:0]==1, shift_sample_rate_o <= {data[31:18], enc} with enc = 15 - msb_index(data[17:2]), or 16 when data[17:2]==0; otherwise shift_sample_rate_o <= data[20:2].
REQ-021 Snapshot FSM states IDLE, CAPTURE, READY. CS write to STATS_SNAP: IDLE/READY -> CAPTURE; in CAPTURE, all N_CNT counters latch into a snapshot array in the same cycle, index <= 0, then -> READY.
REQ-022 CS write to STATS_IDX in READY sets index <= data modulo-checked; index >= N_CNT SHALL set the error flag and leave index unchanged.
REQ-023 CS read of STATS_DATA in READY returns snapshot[index] and post-increments index, wrapping N_CNT-1 -> 0; in IDLE/CAPTURE it returns 0.
REQ-024 STATS_STATUS read returns {29'b0, err, state[1:0]}; reading it clears err.
REQ-025 CS read of CACHE_BASE+4*i returns comm_cache_i word i for i < N_CACHE, else 0.
REQ-026 A STATS_SNAP write concurrent with a STATS_DATA read SHALL return the old snapshot word and then restart the capture.

Reset
REQ-027 On cpu_resetn_i low: reset_reg=0, all control outputs 0, snapshot array 0, index 0, err 0, state IDLE, data_core_o = data_cs_o = 32'hDEADBEAF.
REQ-028 Reset assertion mid-sequence SHALL abort the snapshot and return to IDLE immediately without waiting for a clock edge.

Structure
REQ-029 Register offsets (MAILBOX, COMM_CONTROL, PHASE, METRIC, RESET_CONTROL, STATS_SNAP, STATS_IDX, STATS_DATA, STATS_STATUS, CACHE_BASE), FSM state encoding and the DEADBEAF constant SHALL reside in the shared peripheral package.
REQ-030 The snapshot FSM, array and index SHALL be one sub-module, stats_snapshot; the shift encoder remains inline.

Verification
REQ-031 Reset, then CS write RESET_CONTROL=3 -> reset_system_o=1; CS read RESET_CONTROL -> 32'hFFFFFFFF.
REQ-032 Same-cycle core MAILBOX=0x11 and CS MAILBOX=0x22 -> both ports read 0x22.
REQ-033 CS METRIC write 0x00000005 (sel=1, field=1) -> shift_sample_rate_o=15; field 0 -> 16; field 0x8000 -> 0.
REQ-034 N_CNT=6, counters k=0x100+k, STATS_SNAP, then seven STATS_DATA reads -> 0x100..0x105, then 0x100 (wrap).
REQ-035 STATS_IDX=6 -> STATUS err=1, index unchanged; second STATUS read -> err=0.
REQ-036 Core PHASE write 0x5 -> phase_o=0x80000005 for one cycle, then 0x00000005; CS COMM_CONTROL 0x00C00000 -> comm_o[23:22] high one cycle only.
